// File: rtl/delay_line_sched_if.sv
// Requester/consumer bundle for delay_line_sched; the optional grant_cnt
// signal exists only when SCHED_GRANT_CNT_EN is defined.
interface delay_line_sched_if #(
    parameter int NREQ = 4,
    parameter int IW   = 2,
    parameter int DW   = 8
);
    logic                 run;
    logic                 hold;
    logic [NREQ-1:0]      req;
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ-1:0]      grant;
    logic                 out_valid;
    logic [DW-1:0]        out_data;
    logic [IW-1:0]        out_id;
    logic                 busy;
    logic                 done;
`ifdef SCHED_GRANT_CNT_EN
    logic [15:0]          grant_cnt;

    modport master (
        output run, hold, req, req_data,
        input  grant, out_valid, out_data, out_id, busy, done, grant_cnt
    );
    modport slave (
        input  run, hold, req, req_data,
        output grant, out_valid, out_data, out_id, busy, done, grant_cnt
    );
`else
    modport master (
        output run, hold, req, req_data,
        input  grant, out_valid, out_data, out_id, busy, done
    );
    modport slave (
        input  run, hold, req, req_data,
        output grant, out_valid, out_data, out_id, busy, done
    );
`endif
endinterface

// File: rtl/delay_line_sched.sv
// Round-robin scheduler feeding a shared DEPTH-stage tagged delay line with a
// run/drain FSM. Optional grant counter enabled by SCHED_GRANT_CNT_EN.
module delay_line_sched #(
    parameter int NREQ  = 4,
    parameter int IW    = 2,
    parameter int DW    = 8,
    parameter int DEPTH = 3
) (
    input  logic               clock,
    input  logic               reset_n,
    delay_line_sched_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Every stage except the last; all clear means the line is empty after the next shift.
    localparam logic [DEPTH-1:0] LOW_MASK = DEPTH'((32'd1 << (DEPTH - 1)) - 32'd1);

    state_t            state_r;
    logic [IW-1:0]     ptr_r;
    logic              done_r;
    logic [DEPTH-1:0]  valid_r;
    logic [IW-1:0]     id_r   [DEPTH];
    logic [DW-1:0]     data_r [DEPTH];

    logic [NREQ-1:0]   grant_s;
    logic              grant_any_s;
    logic [IW-1:0]     grant_idx_s;
    logic [DW-1:0]     word_s;

    // Round-robin pick: first asserted request at or after ptr+1, wrapping.
    always_comb begin
        int cand;
        cand        = 0;
        grant_s     = '0;
        grant_any_s = 1'b0;
        grant_idx_s = '0;
        word_s      = '0;
        if (state_r == ST_RUN && bus.run && !bus.hold) begin
            for (int k = 1; k <= NREQ; k++) begin
                cand = (int'(ptr_r) + k) % NREQ;
                if (!grant_any_s && bus.req[cand]) begin
                    grant_any_s   = 1'b1;
                    grant_idx_s   = IW'(cand);
                    grant_s[cand] = 1'b1;
                    word_s        = bus.req_data[cand*DW +: DW];
                end else begin
                    grant_any_s = grant_any_s;
                end
            end
        end else begin
            grant_any_s = 1'b0;
        end
    end

    // Delay line: load stage 0 with the granted entry and shift on every non-hold cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_r <= '0;
            for (int s = 0; s < DEPTH; s++) begin
                id_r[s]   <= '0;
                data_r[s] <= '0;
            end
        end else if (!bus.hold) begin
            for (int s = DEPTH - 1; s > 0; s--) begin
                valid_r[s] <= valid_r[s-1];
                id_r[s]    <= id_r[s-1];
                data_r[s]  <= data_r[s-1];
            end
            valid_r[0] <= grant_any_s;
            id_r[0]    <= grant_idx_s;
            data_r[0]  <= word_s;
        end else begin
            valid_r <= valid_r;
        end
    end

    // Run/drain state machine with round-robin pointer and done pulse.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            ptr_r   <= IW'(NREQ - 1);
            done_r  <= 1'b0;
        end else if (bus.hold) begin
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (grant_any_s) begin
                ptr_r <= grant_idx_s;
            end else begin
                ptr_r <= ptr_r;
            end
            case (state_r)
                ST_IDLE: begin
                    if (bus.run) state_r <= ST_RUN;
                    else         state_r <= ST_IDLE;
                end
                ST_RUN: begin
                    if (!bus.run) state_r <= ST_DRAIN;
                    else          state_r <= ST_RUN;
                end
                ST_DRAIN: begin
                    // Stage 0 loads invalid here, so only the upper stages decide emptiness.
                    if ((valid_r & LOW_MASK) == '0) begin
                        state_r <= ST_IDLE;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= ST_DRAIN;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef SCHED_GRANT_CNT_EN
    logic [15:0] grant_cnt_r;

    // Free-running count of issued grants, wrapping at 16 bits.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            grant_cnt_r <= 16'd0;
        end else if (grant_any_s) begin
            grant_cnt_r <= grant_cnt_r + 16'd1;
        end else begin
            grant_cnt_r <= grant_cnt_r;
        end
    end

    assign bus.grant_cnt = grant_cnt_r;
`endif

    assign bus.grant     = grant_s;
    assign bus.out_valid = valid_r[DEPTH-1];
    assign bus.out_data  = data_r[DEPTH-1];
    assign bus.out_id    = id_r[DEPTH-1];
    assign bus.busy      = |valid_r;
    assign bus.done      = done_r;

endmodule

// File: tb/tb_delay_line_sched.sv
// Randomised and directed bench for delay_line_sched against a timestamp-based
// reference model (words keyed by the shift count at which they were accepted).
module tb_delay_line_sched;
    localparam int NREQ  = 4;
    localparam int IW    = 2;
    localparam int DW    = 8;
    localparam int DEPTH = 3;
    localparam int VW    = NREQ + 1 + IW + DW + 2;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    delay_line_sched_if #(.NREQ(NREQ), .IW(IW), .DW(DW)) bus ();

    delay_line_sched #(.NREQ(NREQ), .IW(IW), .DW(DW), .DEPTH(DEPTH)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef enum {M_IDLE, M_RUN, M_DRAIN} mode_t;
    mode_t               m_mode;
    int                  m_ptr;
    int                  m_adv;
    logic                m_done;
    logic [IW+DW-1:0]    m_line [int];
    int                  n_cmp = 0;
    int                  n_bad = 0;

    function automatic void model_reset();
        m_line.delete();
        m_mode = M_IDLE;
        m_ptr  = NREQ - 1;
        m_adv  = 0;
        m_done = 1'b0;
    endfunction

    function automatic int model_pick();
        if (bus.hold || m_mode != M_RUN || !bus.run) return -1;
        for (int k = 1; k <= NREQ; k++) begin
            if (bus.req[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic bit model_empty();
        for (int s = 1; s <= DEPTH; s++) if (m_line.exists(m_adv - s)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [VW-1:0] model_vec();
        logic [NREQ-1:0]  g;
        logic             v;
        logic [IW+DW-1:0] e;
        int               p;
        g = '0; v = 1'b0; e = '0;
        p = model_pick();
        if (p >= 0) g[p] = 1'b1;
        if (m_line.exists(m_adv - DEPTH)) begin
            v = 1'b1;
            e = m_line[m_adv - DEPTH];
        end
        return {g, v, e, !model_empty(), m_done};
    endfunction

    function automatic logic [VW-1:0] dut_vec();
        logic [IW+DW-1:0] e;
        e = bus.out_valid ? {bus.out_id, bus.out_data} : '0;
        return {bus.grant, bus.out_valid, e, bus.busy, bus.done};
    endfunction

    // Advance one clock and step the model with the inputs seen before the edge.
    task automatic tick();
        int p; logic h, r; logic [DW-1:0] w;
        p = model_pick(); h = bus.hold; r = bus.run; w = '0;
        if (p >= 0) w = bus.req_data[p*DW +: DW];
        @(posedge clock);
        m_done = 1'b0;
        if (!h) begin
            if (p >= 0) begin
                m_line[m_adv] = {IW'(p), w};
                m_ptr = p;
            end
            m_adv++;
            if (m_line.exists(m_adv - DEPTH - 1)) m_line.delete(m_adv - DEPTH - 1);
            case (m_mode)
                M_IDLE:  if (r)  m_mode = M_RUN;
                M_RUN:   if (!r) m_mode = M_DRAIN;
                default: if (model_empty()) begin m_mode = M_IDLE; m_done = 1'b1; end
            endcase
        end
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        bus.run = 1'b1; bus.hold = 1'b0; bus.req = 4'b1111; bus.req_data = 32'h44332211;
        model_reset();
        @(negedge clock);
        #1;
        n_cmp++;
        if ({bus.grant, bus.out_valid, bus.out_data, bus.out_id, bus.busy, bus.done} !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got grant=%b ov=%b od=%h oid=%0d busy=%b done=%b required all zero",
                     bus.grant, bus.out_valid, bus.out_data, bus.out_id, bus.busy, bus.done);
        end
        bus.run = 1'b0; bus.req = 4'b0000;
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        n_cmp++;
        if (dut_vec() !== model_vec()) begin
            n_bad++;
            $display("FAIL reset_release: got %h required %h", dut_vec(), model_vec());
        end
        tick();
    endtask

    task automatic test_single();
        bus.run = 1'b1; bus.req = 4'b0000;
        tick();
        bus.req = 4'b0001; bus.req_data = 32'h000000A5;
        #1;
        n_cmp++;
        if (bus.grant !== 4'b0001) begin
            n_bad++;
            $display("FAIL single_grant: got %b required 0001", bus.grant);
        end
        tick();
        bus.req = 4'b0000;
        for (int c = 1; c <= 4; c++) begin
            #1;
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_bad++;
                $display("FAIL single_cycle%0d: got %h required %h", c, dut_vec(), model_vec());
            end
            if (c == 3) begin
                n_cmp++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hA5 || bus.out_id !== 2'd0) begin
                    n_bad++;
                    $display("FAIL single_out: got v=%b d=%h id=%0d required v=1 d=a5 id=0",
                             bus.out_valid, bus.out_data, bus.out_id);
                end
            end
            if (c == 4) begin
                n_cmp++;
                if (bus.out_valid !== 1'b0) begin
                    n_bad++;
                    $display("FAIL single_gone: got out_valid=%b required 0", bus.out_valid);
                end
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] words [NREQ];
        for (int i = 0; i < NREQ; i++) begin
            words[i] = DW'(8'h30 + 8'h11 * i);
            bus.req_data[i*DW +: DW] = words[i];
        end
        do_reset();
        bus.run = 1'b1; bus.hold = 1'b0; bus.req = 4'b0000;
        tick();
        for (int k = 0; k < 12; k++) begin
            bus.req = (k < 8) ? 4'b1111 : 4'b0000;
            #1;
            n_cmp++;
            if (bus.grant !== ((k < 8) ? (4'b0001 << (k % NREQ)) : 4'b0000)) begin
                n_bad++;
                $display("FAIL b2b_grant k=%0d: got %b", k, bus.grant);
            end
            if (k >= 3 && k < 11) begin
                n_cmp++;
                if (bus.out_valid !== 1'b1 || bus.out_id !== IW'((k - 3) % NREQ)
                    || bus.out_data !== words[(k - 3) % NREQ]) begin
                    n_bad++;
                    $display("FAIL b2b_out k=%0d: got v=%b id=%0d d=%h required v=1 id=%0d d=%h",
                             k, bus.out_valid, bus.out_id, bus.out_data, (k - 3) % NREQ, words[(k - 3) % NREQ]);
                end
            end
            tick();
        end
    endtask

    task automatic test_hold();
        bus.run = 1'b1; bus.req = 4'b1010;
        for (int k = 0; k < 14; k++) begin
            bus.hold = (k == 4 || k == 5);
            #1;
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_bad++;
                $display("FAIL hold_cycle%0d: got %h required %h", k, dut_vec(), model_vec());
            end
            if (bus.hold) begin
                n_cmp++;
                if (bus.grant !== 4'b0000) begin
                    n_bad++;
                    $display("FAIL hold_grant: got %b required 0000", bus.grant);
                end
            end
            tick();
        end
        bus.hold = 1'b0;
    endtask

    task automatic test_drain();
        int dones;
        dones = 0;
        bus.run = 1'b1; bus.hold = 1'b0; bus.req = 4'b1111;
        for (int k = 0; k < 3; k++) tick();
        bus.run = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #1;
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_bad++;
                $display("FAIL drain_cycle%0d: got %h required %h", k, dut_vec(), model_vec());
            end
            n_cmp++;
            if (bus.done !== (k == 3)) begin
                n_bad++;
                $display("FAIL drain_done k=%0d: got %b required %b", k, bus.done, k == 3);
            end
            if (bus.done === 1'b1) dones++;
            tick();
        end
        n_cmp++;
        if (dones !== 1 || bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL drain_summary: got dones=%0d busy=%b required 1 and 0", dones, bus.busy);
        end
        bus.run = 1'b1;
        #1;
        n_cmp++;
        if (bus.grant !== 4'b0000) begin
            n_bad++;
            $display("FAIL drain_idle: got grant=%b in idle, required 0000", bus.grant);
        end
        tick();
    endtask

    task automatic test_reset_midflight();
        bus.run = 1'b1; bus.req = 4'b1111;
        tick();
        tick();
        #1;
        reset_n = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.grant !== 4'b0000) begin
            n_bad++;
            $display("FAIL midflight_reset: got ov=%b busy=%b grant=%b required 0 0 0000",
                     bus.out_valid, bus.busy, bus.grant);
        end
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        #1;
        n_cmp++;
        if (bus.grant !== 4'b0001) begin
            n_bad++;
            $display("FAIL midflight_first_grant: got %b required 0001", bus.grant);
        end
        tick();
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            bus.req      = NREQ'($urandom_range(0, 15));
            bus.req_data = $urandom;
            bus.hold     = ($urandom_range(0, 4) == 0);
            bus.run      = ($urandom_range(0, 9) != 0);
            #1;
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_bad++;
                $display("FAIL random_cycle%0d: got %h required %h", k, dut_vec(), model_vec());
            end
            tick();
        end
        bus.hold = 1'b0;
    endtask

`ifdef SCHED_GRANT_CNT_EN
    task automatic test_grant_cnt();
        do_reset();
        bus.run = 1'b1; bus.hold = 1'b0; bus.req = 4'b0000;
        tick();
        bus.req = 4'b1111;
        for (int k = 0; k < 70000; k++) tick();
        bus.req = 4'b0000;
        #1;
        n_cmp++;
        if (bus.grant_cnt !== 16'd4464) begin
            n_bad++;
            $display("FAIL grant_cnt: got %0d required 4464", bus.grant_cnt);
        end
    endtask
`endif

    initial begin
        bus.run = 1'b0; bus.hold = 1'b0; bus.req = '0; bus.req_data = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_hold();
        test_drain();
        test_reset_midflight();
        test_random();
`ifdef SCHED_GRANT_CNT_EN
        test_grant_cnt();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/delay_line_sched.md
# delay_line_sched

Round-robin scheduler that shares one fixed-depth registered delay line between NREQ requesters. Each cycle it grants at most one requester, loads that requester's word and ID into stage 0, and shifts all stages together, so every accepted word comes out exactly DEPTH cycles later with its source ID. A run/drain state machine allows software to stop intake cleanly and learn when the line is empty. It sits between requester front-ends and any consumer that needs a uniformly delayed, tagged stream.

## Interface
- NREQ, 4: number of requesters (2..8).
- IW, 2: ID width; ceil(log2(NREQ)) or more.
- DW, 8: data word width.
- DEPTH, 3: delay-line stages (1..16).
- clock  in  1  rising-edge clock, single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- run  in  1  level; 1 = accept requests, 0 = stop intake and drain.
- hold  in  1  level; 1 = freeze the whole line, no grants, no shifts.
- req  in  NREQ  per-requester request, level.
- req_data  in  NREQ*DW  requester i word at bits [i*DW +: DW].
- grant  out  NREQ  one-hot or zero; combinational; data sampled this cycle.
- out_valid  out  1  last stage holds a valid word.
- out_data  out  DW  last-stage word.
- out_id  out  IW  requester index of out_data.
- busy  out  1  any stage valid.
- done  out  1  one-cycle pulse on DRAIN to IDLE.

## Operation
- Each stage is {valid, id[IW], data[DW]}. Outputs are driven directly from the last stage.
- States: IDLE, RUN, DRAIN. The reset state is IDLE.
- IDLE: no grants; the line shifts, which only moves invalid entries. run=1 moves to RUN.
- RUN: if hold=0, pick the first asserted req at or after ptr+1, wrapping modulo NREQ. Assert that grant bit, load stage 0 with {1, index, word}, and set ptr to the index. If no req is asserted, load stage 0 with valid=0. run=0 moves to DRAIN; no grant is issued in that cycle.
- DRAIN: no grants; the line shifts while hold=0. When every stage is invalid, move to IDLE and pulse done. run=1 during DRAIN does not abort the drain; the next pass through IDLE re-enters RUN.
- hold=1 in any state: grant=0, stages, ptr and state are all frozen, and done is suppressed.
- Requesters keep req_data stable while req=1 and may hold req for back-to-back words. The round-robin order guarantees that no requester waits more than NREQ-1 grants.
- The line shifts every non-hold cycle. No back-pressure is applied from the output.
- Reset (reset_n=0, at any time including mid-operation):
  - all stage valids, ptr and state clear immediately, with ptr set to NREQ-1 so index 0 wins first;
  - outputs go out_valid=0, out_data=0, out_id=0, busy=0, done=0, grant=0;
  - in-flight words are discarded.

## Timing
- Grant cycle t: the word is sampled on the edge that ends cycle t.
- Output: out_valid=1 with that word in cycle t+DEPTH, assuming no hold. Each hold cycle adds one cycle of delay.
- Throughput: one word per cycle.
- grant depends combinationally on req, ptr, state, run and hold. There is no combinational path from req_data to any output.
- done asserts in the cycle after the last valid word leaves the last stage, i.e. the first cycle in which the line is empty.

## Configuration
- SCHED_GRANT_CNT_EN defined: adds output grant_cnt out 16. It counts issued grants, wraps from 0xFFFF to 0, and is reset to 0 by reset_n.
- SCHED_GRANT_CNT_EN undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Reset, then run=1 with req=4'b0001 and req_data[7:0]=0xA5 for one cycle (cycle t) -> grant=4'b0001 in cycle t; out_valid=1, out_data=0xA5, out_id=0 in cycle t+3; out_valid=0 in cycle t+4.
- req=4'b1111 held for 8 cycles with distinct words -> grant sequence 0,1,2,3,0,1,2,3; output IDs follow the same order 3 cycles later with no gaps.
- req=4'b1010 held, then hold=1 for 2 cycles mid-stream -> grant=0 and outputs frozen during hold; every word arrives exactly 2 cycles later than it would have without hold; grants resume alternating 1,3.
- Line holding 3 valid words, run dropped to 0 -> no further grants; all 3 words emerge; done pulses exactly once, in the cycle after the last word; state returns to IDLE; busy=0.
- reset_n pulsed low while 2 words are in flight -> out_valid, busy and grant go to 0 immediately; after release, the first grant to req=4'b1111 goes to index 0.
- With SCHED_GRANT_CNT_EN defined, 70000 grants -> grant_cnt = 70000 mod 65536 = 4464.
